// File: rtl/sar12_ctrl.sv
// Successive-approximation search controller.
// Walks a trial code MSB-first against an external magnitude comparator
// (target on A, TRIAL on B) and reports the converged code.
module sar12_ctrl #(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic             GT,
    input  logic             LT,
    output logic [WIDTH-1:0] TRIAL,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             EXACT
);

    localparam int CW = $clog2(SETTLE) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] MSB      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // Bit index kept one-hot so stepping to the next bit is a shift, not a subtract.
    logic [WIDTH-1:0] bit_sel;

    logic             is_equal;
    logic [WIDTH-1:0] decided;

    // Decision on the current bit: keep only on a clean GT; LT or the illegal
    // GT&LT both clear it.
    always_comb begin
        is_equal = !GT && !LT;
        decided  = (GT && !LT) ? TRIAL : (TRIAL & ~bit_sel);
    end

    // Conversion FSM; all outputs are registered here.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_sel <= '0;
            TRIAL   <= '0;
            RESULT  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            EXACT   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        TRIAL   <= MSB;
                        bit_sel <= MSB;
                        cnt     <= '0;
                        BUSY    <= 1'b1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ABORT) begin
                        // Abort wins over any decision due on this edge.
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                        TRIAL <= '0;
                        cnt   <= '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (is_equal) begin
                        // Comparator reports a match: stop early on this code.
                        state  <= S_IDLE;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= TRIAL;
                        TRIAL  <= TRIAL;
                        EXACT  <= 1'b1;
                    end else if (bit_sel[0]) begin
                        // LSB decided: the search is complete.
                        state  <= S_IDLE;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        RESULT <= decided;
                        TRIAL  <= decided;
                        EXACT  <= 1'b0;
                    end else begin
                        TRIAL   <= decided | (bit_sel >> 1);
                        bit_sel <= bit_sel >> 1;
                        cnt     <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar12_ctrl.sv
// Directed bench for sar12_ctrl: comparator model in the bench, two
// instances (SETTLE=2 and SETTLE=1), hand-computed expectations.
module tb_sar12_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start0, start1, abort0, abort1;
    logic [11:0] tgt;
    int          mode;   // 0 digital target, 1 analog 2047.5, 2 illegal GT&LT

    logic        gt0, lt0, gt1, lt1;
    logic [11:0] trial0, result0, trial1, result1;
    logic        busy0, done0, exact0, busy1, done1, exact1;

    int errors = 0;
    int checks = 0;
    logic [11:0] tlog [0:40];

    function automatic logic [1:0] cmp(input logic [11:0] tr, input logic [11:0] t, input int md);
        case (md)
            1:       cmp = {tr <= 12'd2047, tr >= 12'd2048};
            2:       cmp = 2'b11;
            default: cmp = {t > tr, t < tr};
        endcase
    endfunction

    always_comb {gt0, lt0} = cmp(trial0, tgt, mode);
    always_comb {gt1, lt1} = cmp(trial1, tgt, mode);

    sar12_ctrl #(.WIDTH(12), .SETTLE(2)) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start0), .ABORT(abort0),
        .GT(gt0), .LT(lt0), .TRIAL(trial0), .RESULT(result0),
        .BUSY(busy0), .DONE(done0), .EXACT(exact0)
    );

    sar12_ctrl #(.WIDTH(12), .SETTLE(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1),
        .GT(gt1), .LT(lt1), .TRIAL(trial1), .RESULT(result1),
        .BUSY(busy1), .DONE(done1), .EXACT(exact1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse START for one instance (edge 0), then wait up to 40 edges for DONE.
    task automatic run(input bit which, input logic [11:0] t, input int md, output int de);
        tgt  = t;
        mode = md;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        tlog[0] = trial0;
        de = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            tlog[e] = trial0;
            if (which ? done1 : done0) begin
                de = e;
                break;
            end
        end
    endtask

    initial begin
        int de, nd, first;
        int pulses [0:3];

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        tgt = '0; mode = 0;
        #12;
        chk("rst_trial",  trial0,  0);
        chk("rst_result", result0, 0);
        chk("rst_busy",   busy0,   0);
        chk("rst_done",   done0,   0);
        chk("rst_exact",  exact0,  0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // T=0x9A3: trial walk and exact match on the last bit
        run(0, 12'h9A3, 0, de);
        chk("seq_e0",  tlog[0],  12'h800);
        chk("seq_e1",  tlog[1],  12'h800);
        chk("seq_e2",  tlog[2],  12'hC00);
        chk("seq_e4",  tlog[4],  12'hA00);
        chk("seq_e6",  tlog[6],  12'h900);
        chk("seq_e8",  tlog[8],  12'h980);
        chk("seq_e10", tlog[10], 12'h9C0);
        chk("seq_e12", tlog[12], 12'h9A0);
        chk("9a3_edge",   de,      24);
        chk("9a3_result", result0, 12'h9A3);
        chk("9a3_exact",  exact0,  1);
        chk("9a3_busy",   busy0,   0);
        @(posedge clk); #1;
        chk("9a3_pulse",  done0,   0);

        run(0, 12'h800, 0, de);
        chk("800_edge",   de,      2);
        chk("800_result", result0, 12'h800);
        chk("800_exact",  exact0,  1);

        run(0, 12'h000, 0, de);
        chk("000_edge",   de,      24);
        chk("000_result", result0, 12'h000);
        chk("000_exact",  exact0,  0);

        run(0, 12'h000, 2, de);
        chk("ill_edge",   de,      24);
        chk("ill_result", result0, 12'h000);

        run(0, 12'hFFF, 0, de);
        chk("fff_edge",   de,      24);
        chk("fff_result", result0, 12'hFFF);
        chk("fff_exact",  exact0,  1);

        // Abort sampled at edge 9; RESULT/EXACT from the 0xFFF run survive
        tgt = 12'h9A3; mode = 0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (8) @(posedge clk);
        #1 abort0 = 1'b1;
        @(posedge clk); #1;
        abort0 = 1'b0;
        chk("abt_busy",   busy0,   0);
        chk("abt_trial",  trial0,  0);
        chk("abt_result", result0, 12'hFFF);
        chk("abt_exact",  exact0,  1);
        nd = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        chk("abt_nodone", nd, 0);

        run(0, 12'h000, 1, de);
        chk("ana_edge",   de,      24);
        chk("ana_result", result0, 12'h7FF);
        chk("ana_exact",  exact0,  0);

        run(1, 12'h000, 1, de);
        chk("s1_edge",   de,      12);
        chk("s1_result", result1, 12'h7FF);
        chk("s1_exact",  exact1,  0);

        // START pulses while busy are dropped
        tgt = 12'h123; mode = 0;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        nd = 0; first = -1;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (done0) begin
                nd++;
                if (first < 0) first = e;
            end
            start0 = (e == 3 || e == 10 || e == 20);
        end
        start0 = 1'b0;
        chk("ign_count", nd,    1);
        chk("ign_edge",  first, 24);

        // START held high: back-to-back conversions
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        nd = 0;
        for (int e = 1; e <= 80; e++) begin
            @(posedge clk); #1;
            if (done0) begin
                if (nd < 4) pulses[nd] = e;
                nd++;
                chk("b2b_result", result0, 12'h123);
            end
        end
        start0 = 1'b0;
        chk("b2b_count", nd, 3);
        chk("b2b_p0", pulses[0], 24);
        chk("b2b_p1", pulses[1], 49);
        chk("b2b_p2", pulses[2], 74);

        // Asynchronous reset between edges while a conversion is running
        #2 rst_n = 1'b0;
        #1;
        chk("arst_trial",  trial0,  0);
        chk("arst_result", result0, 0);
        chk("arst_busy",   busy0,   0);
        chk("arst_done",   done0,   0);
        chk("arst_exact",  exact0,  0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run(0, 12'h9A3, 0, de);
        chk("post_e2",     tlog[2], 12'hC00);
        chk("post_edge",   de,      24);
        chk("post_result", result0, 12'h9A3);
        chk("post_exact",  exact0,  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sar12_ctrl.md
Name: sar12_ctrl

Overview:
Successive-approximation search controller. It drives a 12-bit trial code into the team's 12-bit magnitude comparator (trial on the B side, target on the A side) and consumes the comparator's GT/LT outputs. It converges on the target code bit by bit, MSB first. It sits in the function generator's calibration/readback path: it generates the trial code that the DAC and comparator settle on, and returns the converged code to the control logic.

Parameters:
WIDTH, 12, trial/result width in bits.
SETTLE, 2, cycles from a TRIAL update to the edge at which GT/LT are sampled; legal range 1..15.

Ports:
CLK  input  1  single clock; all state changes on rising edge.
RST_N  input  1  asynchronous, active-low reset.
START  input  1  request a conversion; sampled only in IDLE.
ABORT  input  1  synchronous abort of a running conversion.
GT  input  1  comparator: target > TRIAL.
LT  input  1  comparator: target < TRIAL.
TRIAL  output  WIDTH  current trial code driven to the comparator/DAC.
RESULT  output  WIDTH  converged code; holds until the next completed conversion.
BUSY  output  1  conversion in progress.
DONE  output  1  one-cycle pulse on completion.
EXACT  output  1  last conversion terminated on equality (GT=LT=0).

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset (RST_N low, asynchronous): state=IDLE; TRIAL=0, RESULT=0, BUSY=0, DONE=0, EXACT=0; bit index and settle counter cleared.
- States: IDLE, WAIT.
- IDLE: DONE is driven low each cycle unless set by a finish edge. START=1 at an edge → TRIAL<=1<<(WIDTH-1), idx<=WIDTH-1, cnt<=0, BUSY<=1, go to WAIT.
- WAIT, cnt<SETTLE-1: cnt<=cnt+1; TRIAL stable.
- WAIT, cnt==SETTLE-1 (decision edge): sample GT/LT.
  - GT=1, LT=0: keep bit idx.
  - LT=1, GT=0: clear bit idx.
  - GT=1, LT=1 (illegal): treat as LT and clear bit idx.
  - GT=0, LT=0 (equal): finish immediately with RESULT<=TRIAL and EXACT<=1.
- After a keep/clear decision:
  - idx==0: finish with RESULT<=decided code and EXACT<=0.
  - Otherwise: TRIAL<=decided code | (1<<(idx-1)), idx<=idx-1, cnt<=0.
- Finish edge: state<=IDLE, BUSY<=0, DONE<=1 for exactly the next cycle, TRIAL<=RESULT value.
- Latency: each bit takes exactly SETTLE cycles. With START sampled at edge 0, DONE rises at edge WIDTH*SETTLE (24 at defaults), or at edge k*SETTLE on an equality exit at the k-th bit.
- START while BUSY is ignored and not queued.
- START high in the DONE cycle is accepted; the next conversion begins at the following edge.
- ABORT=1 in WAIT: state<=IDLE, BUSY<=0, TRIAL<=0, no DONE; RESULT and EXACT are unchanged.
- ABORT in IDLE has no effect. ABORT has priority over a same-edge decision.
- START and ABORT asserted together in IDLE: the conversion starts (ABORT only acts in WAIT).
- GT/LT are sampled only on decision edges; glitches between decision edges are ignored.
- RESET asserted mid-conversion: immediate return to reset values; no DONE.
- Arithmetic: bit operations only; no adders besides cnt. cnt width is ceil(log2(SETTLE))+1.

Test Plan:
- Bench comparator model GT=(T>TRIAL), LT=(T<TRIAL). T=0x9A3, SETTLE=2, START pulse at edge 0 → trial sequence 0x800, 0xC00, 0xA00, 0x900, 0x980, 0x9C0, 0x9A0, ... ; DONE at edge 24; RESULT=0x9A3; EXACT=1; BUSY low from edge 24.
- T=0x800 → first decision is equal; DONE at edge 2; RESULT=0x800; EXACT=1. T=0x000 → DONE at edge 24, RESULT=0x000, EXACT=0. T=0xFFF → RESULT=0xFFF, EXACT=1 at edge 24.
- Analog model T=2047.5 (GT/LT never both 0) → RESULT=0x7FF, EXACT=0, DONE at edge 24. Repeat with SETTLE=1 → DONE at edge 12.
- ABORT at edge 9 of a T=0x9A3 conversion → BUSY=0 and TRIAL=0 after edge 9; no DONE; RESULT keeps its previous value. START pulses during BUSY produce no extra DONE.
- Back-to-back: START held high continuously, T=0x123 → DONE pulses exactly one cycle each, conversions restart the edge after each DONE cycle, RESULT=0x123 every time.
- RST_N pulsed low asynchronously mid-WAIT (between edges) → all outputs are 0 immediately; the first conversion after release behaves as in the first scenario.
